// File: rtl/varredura_display_pkg.sv
// Shared definitions for the display scan controller, its decoder and benches.
//   DIGIT_W     : width of one BCD digit
//   MAX_DIGITS  : largest supported digit count
//   ANODE_OFF   : all-anodes-off pattern (active-low), sliced to N_DIGITS by users
//   f_largura   : counter width helper, never returns less than 1
//   f_params_ok : parameter legality check shared by every user of the scan timing
package varredura_display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  function automatic int f_largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit f_params_ok(input int n_digits, input int refresh_div,
                                     input int guard_cycles);
    return (n_digits >= 1) && (n_digits <= MAX_DIGITS) &&
           (guard_cycles >= 0) && (refresh_div >= guard_cycles + 2);
  endfunction

endpackage

// File: rtl/divisor_varredura.sv
// Slot timer for the display scan: owns the in-slot cycle counter and digit index.
// Ports:
//   clk, rst_n     : system clock, async active-low reset
//   o_idx          : digit index of the current slot
//   o_em_guarda    : current cycle lies in the all-anodes-off guard window
//   o_fronteira    : current cycle is the last cycle of the frame
module divisor_varredura
  import varredura_display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16,
  parameter int IDX_W        = f_largura(N_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_em_guarda,
  output logic             o_fronteira
);

  localparam int CNT_W = f_largura(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LIM = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             w_cnt_fim;

  assign w_cnt_fim = (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_fim) begin
      r_cnt <= '0;
      r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_idx       = r_idx;
  assign o_em_guarda = (r_cnt < GUARD_LIM);
  assign o_fronteira = w_cnt_fim && (r_idx == IDX_LAST);

endmodule

// File: rtl/varredura_display.sv
// Time-multiplexed seven-segment scan controller sharing one BCD decoder.
// New digit data is staged in a one-deep buffer and committed only at the frame
// boundary, so a frame never mixes old and new digits.
// Optional build macro: VARREDURA_ZERO_BLANK_EN enables leading-zero suppression.
// Ports:
//   clk, rst_n  : system clock, async active-low reset
//   dados       : N_DIGITS BCD digits, digit 0 in the low nibble
//   carregar    : load strobe, captures dados into the pending buffer
//   BCD         : digit value for the shared decoder (valid from slot start)
//   an_n        : one-hot active-low anode select, all ones = off
//   apagar      : blank request to the segment drivers
//   pendente    : buffered data waiting for the next frame boundary
//   fim_quadro  : one-cycle pulse after each frame boundary
module varredura_display
  import varredura_display_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DIGIT_W*N_DIGITS-1:0] dados,
  input  logic                        carregar,
  output logic [DIGIT_W-1:0]          BCD,
  output logic [N_DIGITS-1:0]         an_n,
  output logic                        apagar,
  output logic                        pendente,
  output logic                        fim_quadro
);

  localparam int IDX_W = f_largura(N_DIGITS);
  localparam int DW    = DIGIT_W * N_DIGITS;
  localparam logic [N_DIGITS-1:0] AN_OFF = ANODE_OFF[N_DIGITS-1:0];

  generate
    if (!f_params_ok(N_DIGITS, REFRESH_DIV, GUARD_CYCLES)) begin : g_param_invalido
      $error("varredura_display: illegal N_DIGITS/REFRESH_DIV/GUARD_CYCLES");
    end
  endgenerate

  logic [IDX_W-1:0]    w_idx;
  logic                w_em_guarda;
  logic                w_fronteira;
  logic [DW-1:0]       r_quadro;
  logic [DW-1:0]       r_buf;
  logic                r_pend;
  logic                r_fim;
  logic [DIGIT_W-1:0]  r_bcd;
  logic [N_DIGITS-1:0] r_an_n;
  logic                r_apagar;
  logic [DIGIT_W-1:0]  w_digito;
  logic [N_DIGITS-1:0] w_blank_dig;
  logic                w_apaga_slot;

  divisor_varredura #(
    .N_DIGITS    (N_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD_CYCLES(GUARD_CYCLES),
    .IDX_W       (IDX_W)
  ) u_divisor (
    .clk        (clk),
    .rst_n      (rst_n),
    .o_idx      (w_idx),
    .o_em_guarda(w_em_guarda),
    .o_fronteira(w_fronteira)
  );

  // Commit uses the buffer contents from before this edge, so a load landing
  // on the boundary goes to the next frame and keeps pendente set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quadro <= '0;
      r_buf    <= '0;
      r_pend   <= 1'b0;
      r_fim    <= 1'b0;
    end else begin
      if (w_fronteira && r_pend) r_quadro <= r_buf;
      if (carregar) begin
        r_buf  <= dados;
        r_pend <= 1'b1;
      end else if (w_fronteira) begin
        r_pend <= 1'b0;
      end
      r_fim <= w_fronteira;
    end
  end

`ifdef VARREDURA_ZERO_BLANK_EN
  // Digit i>0 is suppressed when it and every digit above it are zero.
  always_comb begin
    logic w_zeros_acima;
    w_blank_dig   = '0;
    w_zeros_acima = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      w_zeros_acima  = w_zeros_acima && (r_quadro[i*DIGIT_W +: DIGIT_W] == '0);
      w_blank_dig[i] = w_zeros_acima;
    end
  end
`else
  assign w_blank_dig = '0;
`endif

  assign w_digito     = r_quadro[w_idx*DIGIT_W +: DIGIT_W];
  assign w_apaga_slot = w_em_guarda || w_blank_dig[w_idx];

  // BCD follows the digit for the whole slot so the decoder settles during the guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd    <= '0;
      r_an_n   <= AN_OFF;
      r_apagar <= 1'b1;
    end else begin
      r_bcd    <= w_digito;
      r_an_n   <= w_apaga_slot ? AN_OFF : ~(N_DIGITS'(1) << w_idx);
      r_apagar <= w_apaga_slot;
    end
  end

  assign BCD        = r_bcd;
  assign an_n       = r_an_n;
  assign apagar     = r_apagar;
  assign pendente   = r_pend;
  assign fim_quadro = r_fim;

endmodule

// File: tb/tb_varredura_display.sv
// Bench for varredura_display with N_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2.
// The driver issues one cycle of stimulus per falling edge and queues the outputs
// expected after the following rising edge; the monitor pops and compares them.
module tb_varredura_display;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int G  = 2;
  localparam int FR = N * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] dados = 16'h0;
  logic        carregar = 1'b0;
  logic [3:0]  BCD;
  logic [3:0]  an_n;
  logic        apagar;
  logic        pendente;
  logic        fim_quadro;

  varredura_display #(
    .N_DIGITS    (N),
    .REFRESH_DIV (RD),
    .GUARD_CYCLES(G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dados     (dados),
    .carregar  (carregar),
    .BCD       (BCD),
    .an_n      (an_n),
    .apagar    (apagar),
    .pendente  (pendente),
    .fim_quadro(fim_quadro)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] an;
    logic       apagar;
    logic       pend;
    logic       fim;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: time since reset release, displayed frame, pending buffer.
  int          m_k = 0;
  logic [15:0] m_frame = 16'h0;
  logic [15:0] m_buf = 16'h0;
  logic        m_pend = 1'b0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nome, $time, got, expv);
    end
  endtask

  function automatic bit lead_zero(input logic [15:0] frame, input int s);
`ifdef VARREDURA_ZERO_BLANK_EN
    return (s > 0) && ((frame >> (4 * s)) == 16'h0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   cnt;
    int   s;
    bit   off;
    cnt = m_k % RD;
    s   = (m_k / RD) % N;
    off = (cnt < G) || lead_zero(m_frame, s);
    e.bcd    = 4'((m_frame >> (4 * s)) & 16'hF);
    e.an     = off ? 4'hF : 4'(~(1 << s));
    e.apagar = off;
    e.fim    = ((m_k % FR) == FR - 1);
    e.pend   = 1'b0;
    return e;
  endfunction

  task automatic step(input bit ld, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    rst_n    = 1'b1;
    carregar = ld;
    dados    = d;
    e = model_out();
    if (((m_k % FR) == FR - 1) && m_pend) begin
      m_frame = m_buf;
      m_pend  = 1'b0;
    end
    if (ld) begin
      m_buf  = d;
      m_pend = 1'b1;
    end
    e.pend = m_pend;
    m_k++;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
  endtask

  task automatic run_to(input int fase);
    while ((m_k % FR) != fase) step(1'b0, 16'($urandom));
  endtask

  task automatic reset_cycles(input int n);
    exp_t e;
    e = '{bcd: 4'h0, an: 4'hF, apagar: 1'b1, pend: 1'b0, fim: 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n    = 1'b0;
      carregar = 1'b0;
      m_k = 0; m_frame = 16'h0; m_buf = 16'h0; m_pend = 1'b0;
      q.push_back(e);
      if (i == 0) begin
        #1;
        chk("rst_async_an_n", an_n, 4'hF);
        chk("rst_async_apagar", apagar, 1'b1);
        chk("rst_async_bcd", BCD, 4'h0);
        chk("rst_async_pendente", pendente, 1'b0);
        chk("rst_async_fim", fim_quadro, 1'b0);
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bcd", BCD, e.bcd);
        chk("an_n", an_n, e.an);
        chk("apagar", apagar, e.apagar);
        chk("pendente", pendente, e.pend);
        chk("fim_quadro", fim_quadro, e.fim);
      end
    end
  end

  initial begin : driver
    reset_cycles(3);
    // scan order
    step(1'b1, 16'h4321);
    run(2 * FR + 5);
    // no tearing: second load lands mid-frame
    run_to(10); step(1'b1, 16'h1111);
    run_to(FR - 1); step(1'b0, 16'h0);
    run_to(12); step(1'b1, 16'h9999);
    run(2 * FR);
    // load exactly on the boundary with data pending
    run_to(5); step(1'b1, 16'h2222);
    run_to(FR - 1); step(1'b1, 16'h5555);
    run(2 * FR);
    // reset in slot 2 of a displayed frame
    step(1'b1, 16'h8765);
    run_to(FR - 1); step(1'b0, 16'h0);
    run_to(2 * RD + 3);
    reset_cycles(4);
    run(FR + 5);
    // leading zeros and pass-through of 10..15
    step(1'b1, 16'h0070); run(2 * FR);
    step(1'b1, 16'h0000); run(2 * FR);
    step(1'b1, 16'h0a00); run(2 * FR);
    step(1'b1, 16'hFEDC); run(2 * FR);
    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) reset_cycles($urandom_range(1, 3));
      else step($urandom_range(0, 5) == 0, 16'($urandom));
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
